// File: rtl/frv_mem_req_tracker.sv
// rtl/frv_mem_req_tracker.sv - in-order multi-outstanding LSU request tracker (optional bus error traps: FRV_LSU_BUS_ERR_EN)
module frv_mem_req_tracker #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          flush,
    input  logic          hold_lsu_req,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_load,
    input  logic          req_store,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [4:0]    req_rd,
    output logic          dmem_req,
    output logic          dmem_wen,
    output logic [3:0]    dmem_strb,
    output logic [31:0]   dmem_wdata,
    output logic [31:0]   dmem_addr,
    input  logic          dmem_gnt,
    input  logic          dmem_recv,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_error,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [4:0]    rsp_rd,
    output logic          rsp_load,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_trap,
    output logic [5:0]    rsp_cause,
    output logic [CW-1:0] outstanding
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    rv_ptr_q, rv_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [DEPTH-1:0] recv_q, recv_d;

    logic [4:0]       e_rd_q    [DEPTH];
    logic [1:0]       e_size_q  [DEPTH];
    logic [1:0]       e_off_q   [DEPTH];
    logic [31:0]      e_rdata_q [DEPTH];
    logic [DEPTH-1:0] e_load_q;
    logic [DEPTH-1:0] e_sgn_q;
    logic [DEPTH-1:0] e_mis_q;
    logic [DEPTH-1:0] e_err_q;

    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        full;
    logic        issue_ok;
    logic        mis_take;
    logic        push;
    logic        recv_hit;
    logic        recv_err;
    logic        head_done;
    logic        pop;
    logic [3:0]  strb;
    logic [31:0] wdat;

    `ifdef FRV_LSU_BUS_ERR_EN
    assign recv_err = dmem_error;
    `else
    logic unused_dmem_error;
    assign unused_dmem_error = dmem_error;
    assign recv_err          = 1'b0;
    `endif

    assign is_half    = (req_size == 2'd1);
    assign is_word    = req_size[1];
    assign misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    assign full       = (count_q == CW'(DEPTH));

    // Flush cycle never accepts a new op, aligned or not.
    assign issue_ok = g_resetn && req_valid && !flush && !hold_lsu_req;
    assign dmem_req = issue_ok && !misaligned && !full;
    // An empty tracker also guarantees the response slot is free.
    assign mis_take  = issue_ok && misaligned && (count_q == '0);
    assign push      = (dmem_req && dmem_gnt) || mis_take;
    assign req_ready = push;

    always_comb begin
        strb = 4'b1111;
        wdat = req_wdata;
        case (req_size)
            2'd0: begin
                strb = 4'b0001 << req_addr[1:0];
                wdat = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                strb = 4'b0011 << req_addr[1:0];
                wdat = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign dmem_wen   = dmem_req && req_store;
    assign dmem_strb  = dmem_req ? strb : 4'b0000;
    assign dmem_wdata = dmem_req ? wdat : 32'h0;
    assign dmem_addr  = dmem_req ? {req_addr[31:2], 2'b00} : 32'h0;

    // The recv pointer always sits on the oldest entry still waiting for the bus.
    assign recv_hit  = dmem_recv && vld_q[rv_ptr_q] && !recv_q[rv_ptr_q];
    assign head_done = vld_q[rd_ptr_q] && recv_q[rd_ptr_q];
    assign pop       = head_done && (kill_q[rd_ptr_q] || rsp_ready);

    always_comb begin
        vld_d  = vld_q;
        kill_d = flush ? (kill_q | vld_q) : kill_q;
        recv_d = recv_q;
        if (recv_hit) begin
            recv_d[rv_ptr_q] = 1'b1;
        end
        if (pop) begin
            vld_d[rd_ptr_q]  = 1'b0;
            kill_d[rd_ptr_q] = 1'b0;
            recv_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            vld_d[wr_ptr_q]  = 1'b1;
            kill_d[wr_ptr_q] = 1'b0;
            recv_d[wr_ptr_q] = mis_take;
        end
    end

    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);
    assign rv_ptr_d = rv_ptr_q + PW'(recv_hit) + PW'(mis_take);
    assign count_d  = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rv_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            kill_q   <= '0;
            recv_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rv_ptr_q <= rv_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            kill_q   <= kill_d;
            recv_q   <= recv_d;
        end
    end

    always_ff @(posedge g_clk) begin
        if (push) begin
            e_rd_q[wr_ptr_q]   <= req_rd;
            e_size_q[wr_ptr_q] <= req_size;
            e_off_q[wr_ptr_q]  <= req_addr[1:0];
            e_load_q[wr_ptr_q] <= req_load;
            e_sgn_q[wr_ptr_q]  <= req_signed;
            e_mis_q[wr_ptr_q]  <= mis_take;
            e_err_q[wr_ptr_q]  <= 1'b0;
        end
        if (recv_hit) begin
            e_rdata_q[rv_ptr_q] <= dmem_rdata;
            e_err_q[rv_ptr_q]   <= recv_err;
        end
    end

    logic [4:0]  h_rd;
    logic [1:0]  h_size;
    logic [1:0]  h_off;
    logic [31:0] h_rdata;
    logic        h_load;
    logic        h_sgn;
    logic        h_trap;
    logic [5:0]  h_cause;
    logic [7:0]  h_byte;
    logic [15:0] h_half;
    logic [31:0] h_fmt;

    assign h_rd    = e_rd_q[rd_ptr_q];
    assign h_size  = e_size_q[rd_ptr_q];
    assign h_off   = e_off_q[rd_ptr_q];
    assign h_rdata = e_rdata_q[rd_ptr_q];
    assign h_load  = e_load_q[rd_ptr_q];
    assign h_sgn   = e_sgn_q[rd_ptr_q];
    assign h_trap  = e_mis_q[rd_ptr_q] || e_err_q[rd_ptr_q];
    assign h_byte  = h_rdata[{h_off, 3'b000} +: 8];
    assign h_half  = h_off[1] ? h_rdata[31:16] : h_rdata[15:0];

    always_comb begin
        if (e_mis_q[rd_ptr_q]) begin
            h_cause = h_load ? 6'd4 : 6'd6;
        end else begin
            h_cause = h_load ? 6'd5 : 6'd7;
        end
    end

    always_comb begin
        case (h_size)
            2'd0:    h_fmt = {{24{h_sgn && h_byte[7]}}, h_byte};
            2'd1:    h_fmt = {{16{h_sgn && h_half[15]}}, h_half};
            default: h_fmt = h_rdata;
        endcase
    end

    // Killed heads drain without ever raising rsp_valid.
    assign rsp_valid   = g_resetn && head_done && !kill_q[rd_ptr_q];
    assign rsp_rd      = rsp_valid ? h_rd : 5'd0;
    assign rsp_load    = rsp_valid && h_load;
    assign rsp_trap    = rsp_valid && h_trap;
    assign rsp_cause   = (rsp_valid && h_trap) ? h_cause : 6'd0;
    assign rsp_rdata   = (rsp_valid && h_load && !h_trap) ? h_fmt : 32'h0;
    assign outstanding = g_resetn ? count_q : '0;

endmodule

// File: tb/tb_frv_mem_req_tracker.sv
// tb/tb_frv_mem_req_tracker.sv - directed and random checks of frv_mem_req_tracker against a queue model
module tb_frv_mem_req_tracker;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    `ifdef FRV_LSU_BUS_ERR_EN
    localparam logic       EXP_ST_TRAP  = 1'b1;
    localparam logic [5:0] EXP_ST_CAUSE = 6'd7;
    `else
    localparam logic       EXP_ST_TRAP  = 1'b0;
    localparam logic [5:0] EXP_ST_CAUSE = 6'd0;
    `endif

    logic          g_clk = 1'b0;
    logic          g_resetn;
    logic          flush;
    logic          hold_lsu_req;
    logic          req_valid;
    logic          req_ready;
    logic          req_load;
    logic          req_store;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [4:0]    req_rd;
    logic          dmem_req;
    logic          dmem_wen;
    logic [3:0]    dmem_strb;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_addr;
    logic          dmem_gnt;
    logic          dmem_recv;
    logic [31:0]   dmem_rdata;
    logic          dmem_error;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [4:0]    rsp_rd;
    logic          rsp_load;
    logic [31:0]   rsp_rdata;
    logic          rsp_trap;
    logic [5:0]    rsp_cause;
    logic [CW-1:0] outstanding;

    always #5 g_clk = ~g_clk;

    frv_mem_req_tracker #(.DEPTH(DEPTH)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .hold_lsu_req(hold_lsu_req),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt), .dmem_recv(dmem_recv),
        .dmem_rdata(dmem_rdata), .dmem_error(dmem_error), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rd(rsp_rd), .rsp_load(rsp_load), .rsp_rdata(rsp_rdata), .rsp_trap(rsp_trap),
        .rsp_cause(rsp_cause), .outstanding(outstanding)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic        load;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic        recvd;
        logic        killed;
        logic        trap;
        logic [5:0]  cause;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [31:0] rd, input logic [1:0] sz,
                                        input logic sg, input logic [1:0] off);
        logic [31:0] s;
        s = rd >> (8 * off);
        if (sz == 2'd0) return (sg && s[7]) ? ((s & 32'hFF) | 32'hFFFFFF00) : (s & 32'hFF);
        if (sz == 2'd1) return (sg && s[15]) ? ((s & 32'hFFFF) | 32'hFFFF0000) : (s & 32'hFFFF);
        return rd;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'd0) return 4'b0001 << off;
        if (sz == 2'd1) return 4'b0011 << off;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    task automatic idle();
        req_valid = 0; req_load = 0; req_store = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; req_rd = 0; dmem_gnt = 0; dmem_recv = 0;
        dmem_rdata = 0; dmem_error = 0; rsp_ready = 0; flush = 0; hold_lsu_req = 0;
    endtask

    task automatic setreq(input logic ld, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1; req_load = ld; req_store = !ld; req_size = sz;
        req_signed = sg; req_addr = a; req_wdata = wd; req_rd = rd;
    endtask

    // Compare the current cycle against the model, advance the model, then cross the clock edge.
    task automatic step();
        int   n;
        logic aligned, e_req, e_rdy, hd, e_rv, pop;
        ent_t h, ne;
        n       = mq.size();
        aligned = !((req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'd0));
        e_req   = req_valid && aligned && (n < DEPTH) && !hold_lsu_req && !flush;
        e_rdy   = e_req ? dmem_gnt : (req_valid && !aligned && n == 0 && !hold_lsu_req && !flush);
        hd      = (n > 0) && mq[0].recvd;
        e_rv    = hd && !mq[0].killed;
        chk("outstanding", 32'(outstanding), n);
        chk("dmem_req", dmem_req, e_req);
        chk("req_ready", req_ready, e_rdy);
        chk("rsp_valid", rsp_valid, e_rv);
        if (e_req) begin
            chk("dmem_addr", dmem_addr, req_addr & 32'hFFFFFFFC);
            chk("dmem_wen", dmem_wen, req_store);
            chk("dmem_strb", dmem_strb, exp_strb(req_size, req_addr[1:0]));
            chk("dmem_wdata", dmem_wdata, exp_wdata(req_size, req_wdata));
        end
        if (e_rv) begin
            h = mq[0];
            chk("rsp_rd", rsp_rd, h.rd);
            chk("rsp_load", rsp_load, h.load);
            chk("rsp_trap", rsp_trap, h.trap);
            chk("rsp_cause", rsp_cause, h.cause);
            chk("rsp_rdata", rsp_rdata, h.data);
        end
        pop = hd && (mq[0].killed || rsp_ready);
        if (dmem_recv) begin
            for (int i = 0; i < n; i++) begin
                if (!mq[i].recvd) begin
                    h       = mq[i];
                    h.recvd = 1;
                    h.data  = h.load ? fmt(dmem_rdata, h.size, h.sgn, h.off) : 32'h0;
                    `ifdef FRV_LSU_BUS_ERR_EN
                    if (dmem_error) begin
                        h.trap  = 1;
                        h.cause = h.load ? 6'd5 : 6'd7;
                        h.data  = 0;
                    end
                    `endif
                    mq[i] = h;
                    break;
                end
            end
        end
        if (flush) begin
            for (int i = 0; i < n; i++) begin
                h        = mq[i];
                h.killed = 1;
                mq[i]    = h;
            end
        end
        if (pop) void'(mq.pop_front());
        if (e_rdy) begin
            ne       = '0;
            ne.rd    = req_rd;
            ne.load  = req_load;
            ne.size  = req_size;
            ne.sgn   = req_signed;
            ne.off   = req_addr[1:0];
            ne.recvd = !aligned;
            ne.trap  = !aligned;
            ne.cause = aligned ? 6'd0 : (req_load ? 6'd4 : 6'd6);
            mq.push_back(ne);
        end
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        idle();
        g_resetn = 0;
        setreq(1, 2, 0, 32'h100, 0, 1);
        dmem_gnt  = 1;
        dmem_recv = 1;
        @(posedge g_clk); #1;
        @(posedge g_clk); #1;
        #2;
        chk("reset_dmem_req", dmem_req, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_outstanding", 32'(outstanding), 0);
        chk("reset_strb", dmem_strb, 0);
        @(posedge g_clk); #1;
        idle();
        g_resetn = 1;
        mq.delete();

        // Stray recv with nothing tracked
        dmem_recv = 1; dmem_rdata = 32'h12345678; #2; step();
        idle(); #2; step();

        // Signed then unsigned lb at 0x103
        for (int s = 1; s >= 0; s--) begin
            idle(); setreq(1, 0, s[0], 32'h103, 0, 5); dmem_gnt = 1; #2;
            chk("lb_strb", dmem_strb, 4'b1000);
            chk("lb_addr", dmem_addr, 32'h100);
            step();
            idle(); dmem_recv = 1; dmem_rdata = 32'h80AABBCC; #2;
            chk("lb_rsp_t1", rsp_valid, 0);
            step();
            idle(); rsp_ready = 1; #2;
            chk("lb_rsp_t2", rsp_valid, 1);
            chk("lb_rdata", rsp_rdata, (s != 0) ? 32'hFFFFFF80 : 32'h00000080);
            chk("lb_load", rsp_load, 1);
            step();
        end

        // sh at 0x2002
        idle(); setreq(0, 1, 0, 32'h2002, 32'h1234ABCD, 3); dmem_gnt = 1; #2;
        chk("sh_strb", dmem_strb, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
        chk("sh_addr", dmem_addr, 32'h2000);
        chk("sh_wen", dmem_wen, 1);
        step();
        idle(); dmem_recv = 1; dmem_rdata = 32'h55667788; #2; step();
        idle(); rsp_ready = 1; #2;
        chk("sh_rsp_valid", rsp_valid, 1);
        chk("sh_rsp_load", rsp_load, 0);
        chk("sh_rsp_rdata", rsp_rdata, 0);
        step();

        // Fill to DEPTH, then drain in order while a fifth op waits
        idle();
        for (int i = 0; i < 5; i++) begin
            setreq(1, 2, 0, 32'h300 + 32'(i * 4), 0, 5'(i + 1)); dmem_gnt = 1; #2;
            chk("fill_ready", req_ready, (i < 4) ? 1 : 0);
            step();
        end
        chk("fill_outstanding", 32'(outstanding), 4);
        for (int k = 0; k < 6; k++) begin
            req_valid = (k <= 2); dmem_recv = 1; dmem_rdata = 32'h11111111 * (k + 1); rsp_ready = 1; #2;
            if (k == 1) chk("fifth_blocked", req_ready, 0);
            if (k == 2) chk("fifth_after_pop", req_ready, 1);
            if (k >= 1) chk("drain_order", rsp_rd, k);
            step();
        end
        idle(); #2; chk("fill_empty", 32'(outstanding), 0); step();

        // Misaligned lw with an empty tracker
        setreq(1, 2, 0, 32'h1001, 0, 7); #2;
        chk("mis_no_req", dmem_req, 0);
        chk("mis_ready", req_ready, 1);
        step();
        idle(); rsp_ready = 1; #2;
        chk("mis_trap", rsp_trap, 1);
        chk("mis_cause", rsp_cause, 4);
        step();

        // Misaligned lw behind two outstanding loads
        idle(); rsp_ready = 1;
        setreq(1, 2, 0, 32'h600, 0, 12); dmem_gnt = 1; #2; step();
        setreq(1, 2, 0, 32'h604, 0, 13); #2; step();
        setreq(1, 2, 1, 32'h1001, 0, 14); dmem_recv = 1; dmem_rdata = 32'hA; #2;
        chk("mis_stall0", req_ready, 0);
        step();
        dmem_rdata = 32'hB; #2; chk("mis_stall1", req_ready, 0); step();
        dmem_recv = 0; #2; chk("mis_stall2", req_ready, 0); step();
        #2; chk("mis_go", req_ready, 1); step();
        idle(); rsp_ready = 1; #2; chk("mis2_cause", rsp_cause, 4); step();

        // Flush with two loads in flight
        idle();
        setreq(1, 2, 0, 32'h500, 0, 8); dmem_gnt = 1; #2; step();
        setreq(1, 2, 0, 32'h504, 0, 9); #2; step();
        setreq(1, 2, 0, 32'h508, 0, 10); flush = 1; #2;
        chk("flush_ready", req_ready, 0);
        chk("flush_dreq", dmem_req, 0);
        step();
        flush = 0; dmem_recv = 1; dmem_rdata = 32'h1; rsp_ready = 1; #2;
        chk("post_flush_ready", req_ready, 1);
        step();
        req_valid = 0; dmem_rdata = 32'h2; #2; chk("killed_rsp0", rsp_valid, 0); step();
        dmem_rdata = 32'hCAFEF00D; #2; chk("killed_rsp1", rsp_valid, 0); step();
        dmem_recv = 0; #2;
        chk("post_flush_rsp", rsp_valid, 1);
        chk("post_flush_rd", rsp_rd, 10);
        chk("post_flush_data", rsp_rdata, 32'hCAFEF00D);
        step();
        idle(); #2; chk("flush_empty", 32'(outstanding), 0); step();

        // Store completing with a bus error
        setreq(0, 2, 0, 32'h40, 32'hDEADBEEF, 11); dmem_gnt = 1; #2; step();
        idle(); dmem_recv = 1; dmem_error = 1; #2; step();
        idle(); rsp_ready = 1; #2;
        chk("st_err_trap", rsp_trap, EXP_ST_TRAP);
        chk("st_err_cause", rsp_cause, EXP_ST_CAUSE);
        step();

        // Random traffic
        idle();
        for (int c = 0; c < 3000; c++) begin
            setreq($urandom_range(1, 0), 2'($urandom_range(2, 0)), $urandom_range(1, 0),
                   $urandom, $urandom, 5'($urandom));
            req_valid    = ($urandom_range(2, 0) != 0);
            dmem_gnt     = ($urandom_range(3, 0) != 0);
            dmem_recv    = $urandom_range(1, 0);
            dmem_rdata   = $urandom;
            dmem_error   = ($urandom_range(7, 0) == 0);
            rsp_ready    = ($urandom_range(3, 0) != 0);
            hold_lsu_req = ($urandom_range(9, 0) == 0);
            flush        = ($urandom_range(39, 0) == 0);
            #2; step();
        end
        idle(); dmem_recv = 1; rsp_ready = 1;
        for (int c = 0; c < 12; c++) begin
            #2; step();
        end
        idle(); #2; chk("final_empty", 32'(outstanding), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frv_mem_req_tracker.md
Name: frv_mem_req_tracker

Overview:
Parametrised successor to the single-outstanding LSU path in the memory stage. It accepts load/store ops from the memory stage, checks alignment, and formats the byte strobe and write data. It issues requests on the dmem req/gnt interface and tracks up to DEPTH outstanding transactions in an in-order queue. It formats load data from the in-order dmem response channel and presents one response per op to writeback over a valid/ready handshake.

Parameters:
DEPTH, 4, max outstanding transactions; power of 2, >=2.
CW, $clog2(DEPTH+1), width of outstanding counter (derived, do not override).

Ports:
g_clk  in  1  global clock
g_resetn  in  1  synchronous active-low reset
flush  in  1  kill all tracked ops; their responses are drained silently
hold_lsu_req  in  1  suppress new requests
req_valid  in  1  op valid
req_ready  out  1  op accepted this cycle
req_load / req_store  in  1 / 1  op type (exactly one set)
req_size  in  2  0=byte, 1=half, 2=word
req_signed  in  1  sign-extend load
req_addr  in  32  byte address
req_wdata  in  32  store data (LSB aligned)
req_rd  in  5  destination register
dmem_req  out  1  request
dmem_wen  out  1  write enable
dmem_strb  out  4  byte strobe
dmem_wdata  out  32  lane-replicated write data
dmem_addr  out  32  word-aligned address ({req_addr[31:2],2'b00})
dmem_gnt  in  1  request accepted
dmem_recv  in  1  response valid (in order, never same cycle as its gnt)
dmem_rdata  in  32  response data
dmem_error  in  1  bus error with response
rsp_valid  out  1  writeback response valid
rsp_ready  in  1  writeback accepts
rsp_rd  out  5  destination register
rsp_load  out  1  op was a load
rsp_rdata  out  32  formatted load data; 0 for stores and traps
rsp_trap  out  1  op trapped
rsp_cause  out  6  4=ld misalign, 5=ld access, 6=st misalign, 7=st access
outstanding  out  CW  live tracked entries

Behaviour:
- Reset (already decided): g_resetn synchronous, active-low; clock g_clk. Reset clears pointers, count, and entry valid/kill/recv bits. All outputs are 0 in reset. A dmem_recv arriving after reset with count 0 is ignored.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Aligned issue: dmem_req = req_valid && aligned && !full && !hold_lsu_req. req_ready = dmem_req && dmem_gnt. On grant, push an entry {rd, load, size, signed, addr[1:0], recv=0, kill=0}.
- Misaligned handling: no dmem_req. The op is accepted only when count==0, rsp slot is free, and !hold_lsu_req. It is then pushed as a pre-completed trap entry.
- Strobe: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Loads drive the same strobe with dmem_wen=0.
- Receive: dmem_recv writes rdata/error into the entry at recv pointer and advances the pointer. It is ignored if no entry is awaiting a response.
- Response: head entry with recv=1 drives rsp_* combinationally from entry registers. Pop on rsp_valid && rsp_ready. A killed head with recv=1 pops automatically with rsp_valid=0.
- Load format: shift rdata right by 8*off. Byte extends bit7, half extends bit15, both per signed. Word passes through.
- Latency: min rsp_valid at T+2 for a grant at T with recv at T+1. Back-to-back grants at 1/cycle until full.
- Full: count==DEPTH gives req_ready=0. A same-cycle pop does not free a slot for a push (no bypass).
- Simultaneous push/recv/pop all allowed; count = count + push - pop.
- Pointers wrap modulo DEPTH.
- Flush: sets kill on all valid entries. A req presented in the flush cycle is not accepted. Later requests proceed normally behind killed entries.
- rsp_valid stays high with stable data until rsp_ready.

Optional Feature:
FRV_LSU_BUS_ERR_EN.
- Defined: dmem_error with dmem_recv marks the entry errored. Its response gives rsp_trap=1, cause 5 (load) or 7 (store), rsp_rdata=0.
- Undefined: dmem_error is ignored, and only misalignment traps.

Test Plan:
- Signed lb addr 0x103, gnt T, recv T+1 rdata 0x80AABBCC -> rsp_valid T+2, rsp_rdata 0xFFFFFF80, rsp_load=1. Repeat unsigned -> 0x00000080.
- sh addr 0x2002 wdata 0x1234ABCD -> dmem_strb 4'b1100, dmem_wdata 0xABCDABCD, dmem_addr 0x2000, wen=1. After recv, rsp_load=0, rsp_rdata=0.
- DEPTH=4, 5 loads with gnt=1 and recv held low -> 4 accepted, outstanding=4, req_ready=0 on the 5th. Release recv 4 cycles -> responses in issue order. The 5th is accepted only after the first pop.
- lw addr 0x1001 with count 0 -> no dmem_req, rsp_trap=1, cause 4 next cycle. With 2 outstanding, it stalls until count 0.
- 2 loads outstanding, flush, then new lw -> 2 recvs produce no rsp_valid, new lw response correct, outstanding returns to 0.
- With FRV_LSU_BUS_ERR_EN, store recv with dmem_error=1 -> rsp_trap=1, cause 7. Without the macro -> rsp_trap=0.
